// File: rtl/sv_uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and index-width helper.
// HDR state only exists when SV_UART_ARB_ID_PREFIX_EN is defined.
// No logic here; imported by the arbiter top and the round-robin picker.
package sv_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef SV_UART_ARB_ID_PREFIX_EN
        ST_HDR  = 2'd1,
`endif
        ST_XFER = 2'd2
    } state_t;

    // Port index width; a single-bit index is kept even for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sv_uart_rr_pick.sv
// Round-robin picker: first requester after last_grant, wrapping modulo NPORTS.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module sv_uart_rr_pick
    import sv_uart_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int IW     = idx_w(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     last_grant,
    output logic [NPORTS-1:0] pick,
    output logic [IW-1:0]     pick_idx,
    output logic              pick_vld
);

    int   p;
    logic found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        p        = 0;
        found    = 1'b0;
        for (int k = 1; k <= NPORTS; k++) begin
            p = (int'(last_grant) + k) % NPORTS;
            if (!found && req[p]) begin
                found       = 1'b1;
                pick[p]     = 1'b1;
                pick_idx    = IW'(p);
            end
        end
    end

    assign pick_vld = |req;

endmodule

// File: rtl/sv_uart_tx_arb.sv
// Packet-level round-robin arbiter of NPORTS AXI-stream sources onto one UART byte stream.
// Latency: one IDLE arbitration cycle per packet (plus a port-id header beat with SV_UART_ARB_ID_PREFIX_EN).
// Backpressure: m_axis_tready passes straight through to the granted port; other ports stall.
module sv_uart_tx_arb
    import sv_uart_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 256
) (
    input  logic                         iclk,
    input  logic                         irst,
    input  logic [NPORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NPORTS-1:0]            s_axis_tvalid,
    input  logic [NPORTS-1:0]            s_axis_tlast,
    output logic [NPORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [NPORTS-1:0]            ogrant,
    output logic                         otrunc
);

    localparam int          IW    = idx_w(NPORTS);
    localparam logic [15:0] MAX_B = 16'(MAX_BEATS);

`ifdef SV_UART_ARB_ID_PREFIX_EN
    if ($clog2(NPORTS) > DATA_WIDTH) begin : g_bad_cfg
        $error("sv_uart_tx_arb: port index does not fit in DATA_WIDTH header byte");
    end
`endif

    state_t                state;
    logic [IW-1:0]         last_grant;
    logic [15:0]           beat_cnt;
    logic [NPORTS-1:0]     pick;
    logic [IW-1:0]         pick_idx;
    logic                  pick_vld;
    logic                  g_vld;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_dat;

    sv_uart_rr_pick #(.NPORTS(NPORTS), .IW(IW)) u_pick (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_vld   (pick_vld)
    );

    // last_grant doubles as the owner index while a packet is in flight.
    assign g_vld  = s_axis_tvalid[last_grant];
    assign g_last = s_axis_tlast[last_grant];
    assign g_dat  = s_axis_tdata[last_grant*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        if (!irst) begin
            case (state)
                ST_XFER: begin
                    m_axis_tvalid = g_vld;
                    m_axis_tdata  = g_dat;
                    s_axis_tready = ogrant & {NPORTS{m_axis_tready}};
                end
`ifdef SV_UART_ARB_ID_PREFIX_EN
                ST_HDR: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = DATA_WIDTH'(last_grant);
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= ST_IDLE;
            ogrant     <= '0;
            otrunc     <= 1'b0;
            beat_cnt   <= '0;
            last_grant <= IW'(NPORTS - 1);
        end else begin
            otrunc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        ogrant     <= pick;
                        last_grant <= pick_idx;
                        beat_cnt   <= '0;
`ifdef SV_UART_ARB_ID_PREFIX_EN
                        state      <= ST_HDR;
`else
                        state      <= ST_XFER;
`endif
                    end
                end
`ifdef SV_UART_ARB_ID_PREFIX_EN
                ST_HDR: begin
                    if (m_axis_tready) state <= ST_XFER;
                end
`endif
                ST_XFER: begin
                    if (g_vld && m_axis_tready) begin
                        beat_cnt <= beat_cnt + 16'd1;
                        // tlast wins over the length limit, so a coinciding beat is a normal release
                        if (g_last) begin
                            state  <= ST_IDLE;
                            ogrant <= '0;
                        end else if (beat_cnt + 16'd1 == MAX_B) begin
                            state  <= ST_IDLE;
                            ogrant <= '0;
                            otrunc <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ogrant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sv_uart_tx_arb.sv
// Bench for sv_uart_tx_arb: directed scenarios then random traffic against a behavioural model.
// Header-beat expectations follow SV_UART_ARB_ID_PREFIX_EN.
module tb_sv_uart_tx_arb;

    localparam int NP = 4;
    localparam int MB = 4;
`ifdef SV_UART_ARB_ID_PREFIX_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct {int cyc; int port; logic [7:0] d;} ev_t;

    logic          iclk = 1'b0;
    logic          irst;
    logic [31:0]   s_axis_tdata;
    logic [NP-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready, ogrant;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, otrunc;

    sv_uart_tx_arb #(.NPORTS(NP), .DATA_WIDTH(8), .MAX_BEATS(MB)) dut (
        .iclk(iclk), .irst(irst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .ogrant(ogrant), .otrunc(otrunc)
    );

    always #5 iclk = ~iclk;

    int tests = 0, fails = 0;
    logic [8:0] q [NP][$];
    ev_t dlog[$], hlog[$];
    logic [NP-1:0] en, acc, exp_g, prev_g;
    logic m_rdy, exp_tr;
    bit rnd, tog, chk_on, pend;
    int cyc, lg, bcnt, tcount;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [31:0] dd(int k); return (dlog.size() > k) ? 32'(dlog[k].d) : 'x; endfunction
    function automatic logic [31:0] dp(int k); return (dlog.size() > k) ? 32'(dlog[k].port) : 'x; endfunction
    function automatic logic [31:0] dc(int k); return (dlog.size() > k) ? 32'(dlog[k].cyc) : 'x; endfunction

    task automatic drive();
        logic [8:0] w;
        for (int i = 0; i < NP; i++) begin
            w = (q[i].size() != 0) ? q[i][0] : 9'h0;
            s_axis_tvalid[i]     = en[i] && (q[i].size() != 0);
            s_axis_tdata[i*8 +: 8] = w[7:0];
            s_axis_tlast[i]      = w[8];
        end
        m_axis_tready = m_rdy;
    endtask

    // Spec-level reference: owner, readies, mux, beat count, release and the next round-robin winner.
    task automatic sample();
        logic [NP-1:0] er;
        logic em;
        int g, w, win;
        g = 0;
        for (int i = 0; i < NP; i++) if (ogrant[i] === 1'b1) g = i;
        if (chk_on) begin
            chk("ogrant", 32'(ogrant), 32'(exp_g));
            chk("otrunc", 32'(otrunc), 32'(exp_tr));
        end
        if (otrunc === 1'b1) tcount++;
        if (HDR == 1 && !irst && prev_g == 0 && ogrant != 0) pend = 1;
        er = (!irst && !pend && m_rdy) ? ogrant : '0;
        chk("s_tready", 32'(s_axis_tready), 32'(er));
        em = !irst && (ogrant != 0) && (pend || s_axis_tvalid[g]);
        chk("m_tvalid", 32'(m_axis_tvalid), 32'(em));
        if (em) chk("m_tdata", 32'(m_axis_tdata), pend ? 32'(g) : 32'(s_axis_tdata[g*8 +: 8]));
        acc = s_axis_tvalid & s_axis_tready;
        chk_on = 1;
        exp_tr = 0;
        if (irst) begin
            exp_g = '0; lg = NP - 1; pend = 0; bcnt = 0;
        end else if (ogrant == 0) begin
            exp_g = '0; win = -1;
            for (int k = 1; k <= NP; k++) begin
                w = (lg + k) % NP;
                if (win < 0 && s_axis_tvalid[w]) win = w;
            end
            if (win >= 0) begin exp_g = NP'(1 << win); lg = win; end
            bcnt = 0;
        end else begin
            exp_g = ogrant;
            if (m_axis_tvalid && m_rdy) begin
                if (pend) begin
                    pend = 0;
                    hlog.push_back('{cyc, g, m_axis_tdata});
                end else begin
                    bcnt++;
                    dlog.push_back('{cyc, g, m_axis_tdata});
                    if (s_axis_tlast[g]) exp_g = '0;
                    else if (bcnt == MB) begin exp_g = '0; exp_tr = 1; end
                end
            end
        end
        prev_g = ogrant;
    endtask

    task automatic step();
        #4;
        sample();
        @(posedge iclk);
        #1;
        cyc++;
        for (int i = 0; i < NP; i++) if (acc[i]) void'(q[i].pop_front());
        if (rnd) begin
            for (int i = 0; i < NP; i++) en[i] = ($urandom_range(0, 3) != 0);
            m_rdy = ($urandom_range(0, 2) != 0);
        end else if (tog) m_rdy = ~m_rdy;
        drive();
    endtask

    task automatic run_until_idle(input int bound);
        int n;
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0 || ogrant != 0) && n < bound) begin
            step();
            n++;
        end
        chk("idle_within_bound", 32'(n < bound), 32'd1);
    endtask

    task automatic do_reset();
        irst = 1'b1;
        for (int i = 0; i < NP; i++) q[i].delete();
        en = '1; m_rdy = 1'b1; tog = 0; rnd = 0;
        drive();
        step();
        step();
        irst = 1'b0;
        drive();
        dlog.delete(); hlog.delete(); tcount = 0;
    endtask

    initial begin
        int c0, total, n;
        irst = 1'b1; en = '1; m_rdy = 1'b1; rnd = 0; tog = 0; chk_on = 0; pend = 0;
        prev_g = '0; exp_g = '0; exp_tr = 1'b0; cyc = 0; lg = NP - 1; bcnt = 0; tcount = 0;
        @(posedge iclk);
        #1;
        drive();
        do_reset();
        chk("rst_ogrant", 32'(ogrant), 32'd0);
        chk("rst_otrunc", 32'(otrunc), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Single port, three bytes
        c0 = cyc;
        q[2].push_back({1'b0, 8'h11}); q[2].push_back({1'b0, 8'h22}); q[2].push_back({1'b1, 8'h33});
        drive();
        step();
        chk("s1_grant", 32'(ogrant), 32'b0100);
        run_until_idle(30);
        chk("s1_count", 32'(dlog.size()), 32'd3);
        chk("s1_b0", dd(0), 32'h11);
        chk("s1_b1", dd(1), 32'h22);
        chk("s1_b2", dd(2), 32'h33);
        chk("s1_first_cyc", dc(0), 32'(c0 + 1 + HDR));
        chk("s1_consec", dc(2) - dc(0), 32'd2);
        chk("s1_released", 32'(ogrant), 32'd0);

        // Simultaneous one-byte packets on ports 0,1,3
        do_reset();
        q[0].push_back({1'b1, 8'hA0}); q[1].push_back({1'b1, 8'hA1}); q[3].push_back({1'b1, 8'hA3});
        drive();
        run_until_idle(40);
        chk("s2_p0", dp(0), 32'd0);
        chk("s2_p1", dp(1), 32'd1);
        chk("s2_p2", dp(2), 32'd3);
        chk("s2_d2", dd(2), 32'hA3);
        chk("s2_gap01", dc(1) - dc(0), 32'(2 + HDR));
        chk("s2_gap13", dc(2) - dc(1), 32'(2 + HDR));

        // Backpressure: m_tready toggles every cycle
        do_reset();
        q[0].push_back({1'b0, 8'hB0}); q[0].push_back({1'b1, 8'hB1});
        tog = 1;
        drive();
        run_until_idle(40);
        tog = 0; m_rdy = 1'b1; drive();
        chk("s3_count", 32'(dlog.size()), 32'd2);
        chk("s3_b0", dd(0), 32'hB0);
        chk("s3_b1", dd(1), 32'hB1);

        // Truncation at MAX_BEATS, remainder re-arbitrated
        do_reset();
        for (int b = 0; b < 6; b++) q[1].push_back({b == 5, 8'(8'hC1 + b)});
        drive();
        run_until_idle(60);
        chk("s4_count", 32'(dlog.size()), 32'd6);
        chk("s4_b3", dd(3), 32'hC4);
        chk("s4_b5", dd(5), 32'hC6);
        chk("s4_trunc_pulses", 32'(tcount), 32'd1);
        chk("s4_rearb_gap", dc(4) - dc(3), 32'(2 + HDR));
        chk("s4_port", dp(5), 32'd1);

        // Reset asserted mid-packet
        do_reset();
        q[0].push_back({1'b0, 8'h01}); q[0].push_back({1'b0, 8'h02}); q[0].push_back({1'b1, 8'h03});
        q[1].push_back({1'b1, 8'hD1});
        drive();
        n = 0;
        while (dlog.size() == 0 && n < 20) begin step(); n++; end
        chk("s5_first_byte", 32'(dlog.size()), 32'd1);
        irst = 1'b1;
        drive();
        step();
        chk("s5_rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("s5_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("s5_rst_ogrant", 32'(ogrant), 32'd0);
        step();
        irst = 1'b0;
        drive();
        chk("s5_no_extra_beats", 32'(dlog.size()), 32'd1);
        n = 0;
        while (ogrant == 0 && n < 10) begin step(); n++; end
        chk("s5_port0_wins", 32'(ogrant), 32'b0001);
        run_until_idle(60);
        chk("s5_after_d", dd(1), 32'h02);

        // Port 3 single byte (header beat when the id prefix is built in)
        do_reset();
        q[3].push_back({1'b1, 8'hA5});
        drive();
        run_until_idle(30);
        chk("s6_data", dd(0), 32'hA5);
`ifdef SV_UART_ARB_ID_PREFIX_EN
        chk("s6_hdr_count", 32'(hlog.size()), 32'd1);
        chk("s6_hdr_val", (hlog.size() > 0) ? 32'(hlog[0].d) : 'x, 32'h03);
        chk("s6_hdr_then_data", dc(0), (hlog.size() > 0) ? 32'(hlog[0].cyc + 1) : 'x);
`else
        chk("s6_no_hdr", 32'(hlog.size()), 32'd0);
`endif

        // Random traffic with gaps and backpressure
        do_reset();
        total = 0;
        for (int p = 0; p < 30; p++) begin
            int port, len;
            port = $urandom_range(0, NP - 1);
            len  = $urandom_range(1, 7);
            for (int b = 0; b < len; b++) q[port].push_back({b == len - 1, 8'($urandom)});
            total += len;
        end
        rnd = 1;
        drive();
        run_until_idle(6000);
        rnd = 0;
        chk("rand_all_beats", 32'(dlog.size()), 32'(total));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sv_uart_tx_arb.md
SV_UART_TX_ARB -- requirements
Module: sv_uart_tx_arb

Interface
REQ-001 Parameters SHALL be:
- NPORTS, default 4, number of AXI-stream requesters (2..16).
- DATA_WIDTH, default 8, byte width.
- MAX_BEATS, default 256, forced-release packet length limit (1..65535).
REQ-002 Clock iclk; reset irst, synchronous, active-high.
REQ-003 Ports SHALL be:
- iclk  in  1  clock.
- irst  in  1  synchronous active-high reset.
- s_axis_tdata  in  NPORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NPORTS  per-port valid.
- s_axis_tlast  in  NPORTS  per-port end of packet.
- s_axis_tready  out  NPORTS  per-port ready.
- m_axis_tdata  out  DATA_WIDTH  to UART transmitter.
- m_axis_tvalid  out  1  to UART transmitter.
- m_axis_tready  in  1  from UART transmitter.
- ogrant  out  NPORTS  one-hot current owner; all zero when idle.
- otrunc  out  1  one-cycle pulse on forced release.

Function
REQ-004 The FSM SHALL have states IDLE, HDR and XFER; HDR exists only with the macro in REQ-017.
REQ-005 In IDLE with any s_axis_tvalid set, the block SHALL pick a port round-robin. The search starts at last_grant+1 and wraps modulo NPORTS.
REQ-006 The pick SHALL register ogrant and last_grant, and the FSM SHALL enter XFER (or HDR) on the next edge. This is exactly one arbitration cycle, with no beat transferred in IDLE.
REQ-007 In XFER, m_axis_tdata and m_axis_tvalid SHALL combinationally mirror the granted port. s_axis_tready[g] SHALL equal m_axis_tready. All other readies SHALL be 0.
REQ-008 A beat SHALL be accepted when m_axis_tvalid and m_axis_tready are both 1. A 16-bit beat counter SHALL increment per accepted beat and clear on entry to XFER.
REQ-009 The grant SHALL be held across tvalid gaps of the granted port; m_axis_tvalid is 0 during a gap.
REQ-010 Acceptance of a beat with tlast=1 SHALL return the FSM to IDLE and clear ogrant.
REQ-011 Acceptance of beat number MAX_BEATS with tlast=0 SHALL return the FSM to IDLE, clear ogrant and pulse otrunc for one cycle. Remaining beats of that port then compete as a new packet.
REQ-012 If tlast and the MAX_BEATS limit coincide on the same beat, the release SHALL be normal and otrunc SHALL stay 0.
REQ-013 Requests from non-granted ports SHALL never be dropped, only stalled. Under continuous requests from all ports, each port SHALL be served once every NPORTS packets.

Reset
REQ-014 While irst is 1, all s_axis_tready bits and m_axis_tvalid SHALL be forced to 0 combinationally.
REQ-015 After reset the block SHALL be in state IDLE with:
- ogrant = 0
- otrunc = 0
- beat counter = 0
- last_grant = NPORTS-1, so port 0 wins first.
REQ-016 Reset asserted mid-packet SHALL abandon the packet without further beats. The UART transmitter's own reset is owned by the integrator.

Configuration
REQ-017 With SV_UART_ARB_ID_PREFIX_EN defined, a header state HDR SHALL be inserted between IDLE and XFER:
- m_axis_tvalid = 1.
- m_axis_tdata = granted index, zero-extended to DATA_WIDTH.
- All s_axis_tready = 0.
- Advance to XFER on m_axis_tready.
- The header SHALL NOT count toward MAX_BEATS.
REQ-018 Without SV_UART_ARB_ID_PREFIX_EN, HDR and its logic SHALL be absent, and IDLE SHALL go directly to XFER.
REQ-019 An elaboration-time check SHALL fail if clog2(NPORTS) exceeds DATA_WIDTH while the macro is defined.

Structure
REQ-020 The state enum type and a clog2-based index-width constant function SHALL live in the shared package sv_uart_pkg.
REQ-021 Round-robin selection SHALL be a combinational sub-module, sv_uart_rr_pick, with:
- inputs: request vector and last_grant index.
- outputs: one-hot pick, index and any-valid.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (NPORTS=4, MAX_BEATS=4 unless stated):
- Single port: port 2 sends 3 bytes 0x11,0x22,0x33 (tlast on 0x33) with m_tready held 1 -> ogrant=0100 one cycle after tvalid, bytes output on 3 consecutive cycles, ogrant=0 after.
- Simultaneous: ports 0,1,3 each request one 1-byte packet in the same cycle -> served in order 0,1,3, with one IDLE cycle between packets.
- Backpressure: m_tready toggles 1,0,1,0 during a 2-byte packet -> no byte lost or duplicated, s_tready of the granted port tracks m_tready.
- Truncation: port 1 streams 6 bytes with tlast only on byte 6 -> release after byte 4, otrunc pulses once, bytes 5-6 are re-arbitrated as a new packet.
- Mid-packet reset: irst asserted after byte 1 of 3 -> all readies 0 during irst, ogrant=0, and port 0 wins next.
- Macro build: SV_UART_ARB_ID_PREFIX_EN defined, port 3 sends 0xA5 -> output 0x03, 0xA5.
